// File: rtl/maze_pingpong_ctrl.sv
// Ping-pong maze RAM controller: arbitrates two writers into the back
// bank, runs a back-bank fill engine and swaps banks at vblank start.
// Ports: clk, rst (sync, active-low); hc/vc scan counts;
//   req0_*/req1_* valid/addr/data/ready writers; clear_req/fill_data;
//   swap_req; bank0_we/bank1_we/wr_addr/wr_data shared write port;
//   disp_bank front bank; busy/clear_done/swap_done status; wr_err.
// Optional: MAZE_WR_BOUNDS_EN drops out-of-range writes and flags wr_err.
module maze_pingpong_ctrl #(
  parameter int DEPTH  = 63360,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int VLINES = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              swap_req,
  output logic              bank0_we,
  output logic              bank1_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              disp_bank,
  output logic              busy,
  output logic              clear_done,
  output logic              swap_done,
  output logic              wr_err
);

  localparam logic [9:0] VL = 10'(VLINES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t            state, state_nx;
  logic              swap_pend, pend_nx;
  logic              pref1, pref_nx;
  logic              disp_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] fval, fval_nx;
  logic              fbank, fbank_nx;
  logic              we0_nx, we1_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic              busy_nx, cdone_nx, sdone_nx;

  logic              vblank, swap_go, open, grant;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  assign vblank  = (vc == VL) && (hc == 10'd0);
  assign swap_go = (state == RUN) && swap_pend && vblank;
  // Writers only see ready when nothing higher-priority owns the cycle.
  assign open    = rst && (state == RUN) && !swap_go && !clear_req;

  assign req0_ready = open && req0_valid
                      && (!req1_valid || !pref1);
  assign req1_ready = open && req1_valid
                      && (!req0_valid || pref1);
  assign grant  = req0_ready || req1_ready;
  assign g_addr = req1_ready ? req1_addr : req0_addr;
  assign g_data = req1_ready ? req1_data : req0_data;

`ifdef MAZE_WR_BOUNDS_EN
  logic err_q, err_nx, in_range;
  assign in_range = (g_addr <= LAST);
  assign wr_err   = err_q;
`else
  assign wr_err   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pend_nx  = swap_pend || swap_req;
    pref_nx  = pref1;
    disp_nx  = disp_bank;
    cnt_nx   = cnt;
    fval_nx  = fval;
    fbank_nx = fbank;
    we0_nx   = 1'b0;
    we1_nx   = 1'b0;
    addr_nx  = wr_addr;
    data_nx  = wr_data;
    busy_nx  = busy;
    cdone_nx = 1'b0;
    sdone_nx = 1'b0;
`ifdef MAZE_WR_BOUNDS_EN
    err_nx   = err_q;
`endif
    unique case (state)
      RUN: begin
        if (swap_go) begin
          // A request arriving on the swap cycle is absorbed.
          disp_nx  = !disp_bank;
          sdone_nx = 1'b1;
          pend_nx  = 1'b0;
        end else if (clear_req) begin
          state_nx = CLEAR;
          fval_nx  = fill_data;
          fbank_nx = !disp_bank;
          cnt_nx   = '0;
          addr_nx  = '0;
          data_nx  = fill_data;
          we0_nx   = disp_bank;
          we1_nx   = !disp_bank;
          busy_nx  = 1'b1;
        end else if (grant) begin
          pref_nx = req0_ready;
          addr_nx = g_addr;
          data_nx = g_data;
`ifdef MAZE_WR_BOUNDS_EN
          if (in_range) begin
            we0_nx = disp_bank;
            we1_nx = !disp_bank;
          end else begin
            err_nx = 1'b1;
          end
`else
          we0_nx = disp_bank;
          we1_nx = !disp_bank;
`endif
        end
      end
      CLEAR: begin
        // cnt is the address already on the write port.
        if (cnt == LAST) begin
          state_nx = RUN;
          busy_nx  = 1'b0;
          cdone_nx = 1'b1;
        end else begin
          cnt_nx  = cnt + 1'b1;
          addr_nx = cnt + 1'b1;
          data_nx = fval;
          we0_nx  = !fbank;
          we1_nx  = fbank;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      swap_pend  <= 1'b0;
      pref1      <= 1'b0;
      disp_bank  <= 1'b0;
      cnt        <= '0;
      fval       <= '0;
      fbank      <= 1'b0;
      bank0_we   <= 1'b0;
      bank1_we   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      swap_done  <= 1'b0;
`ifdef MAZE_WR_BOUNDS_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      swap_pend  <= pend_nx;
      pref1      <= pref_nx;
      disp_bank  <= disp_nx;
      cnt        <= cnt_nx;
      fval       <= fval_nx;
      fbank      <= fbank_nx;
      bank0_we   <= we0_nx;
      bank1_we   <= we1_nx;
      wr_addr    <= addr_nx;
      wr_data    <= data_nx;
      busy       <= busy_nx;
      clear_done <= cdone_nx;
      swap_done  <= sdone_nx;
`ifdef MAZE_WR_BOUNDS_EN
      err_q      <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_maze_pingpong_ctrl.sv
// Randomized bench for maze_pingpong_ctrl against a behavioural model
// of arbitration, fill, swap and bounds rules.
module tb_maze_pingpong_ctrl;

  localparam int DEPTH  = 63360;
  localparam int VLINES = 480;
`ifdef MAZE_WR_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  hc = '0, vc = '0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_addr = '0, req1_addr = '0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        clear_req = 1'b0, swap_req = 1'b0;
  logic [7:0]  fill_data = '0;
  logic        bank0_we, bank1_we;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        disp_bank, busy, clear_done, swap_done, wr_err;

  always #5 clk = ~clk;

  maze_pingpong_ctrl dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_req(clear_req), .fill_data(fill_data),
    .swap_req(swap_req),
    .bank0_we(bank0_we), .bank1_we(bank1_we),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .busy(busy),
    .clear_done(clear_done), .swap_done(swap_done),
    .wr_err(wr_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state in plain terms.
  int m_front, m_fill_left, m_fill_next, m_fill_val, m_fill_bank;
  bit m_pend, m_prefer1, m_clearing, m_err;
  bit e_r0, e_r1, e_we0, e_we1, e_busy, e_cdone, e_sdone, e_wr;
  int e_addr, e_data;

  task automatic expect_write(input int bank, input int a, input int d);
    e_we0  = (bank == 0);
    e_we1  = (bank == 1);
    e_wr   = 1'b1;
    e_addr = a;
    e_data = d;
  endtask

  task automatic model_step();
    int who, a, d;
    bit vb;
    e_r0 = 0; e_r1 = 0; e_we0 = 0; e_we1 = 0;
    e_cdone = 0; e_sdone = 0; e_wr = 0;
    if (!rst) begin
      m_front = 0; m_pend = 0; m_prefer1 = 0;
      m_clearing = 0; m_err = 0; e_busy = 0;
      e_wr = 1; e_addr = 0; e_data = 0;
      return;
    end
    vb = (int'(vc) == VLINES) && (hc == 0);
    if (m_clearing) begin
      if (swap_req) m_pend = 1;
      if (m_fill_left > 0) begin
        expect_write(m_fill_bank, m_fill_next, m_fill_val);
        m_fill_next++;
        m_fill_left--;
        e_busy = 1;
      end else begin
        m_clearing = 0;
        e_busy = 0;
        e_cdone = 1;
      end
    end else if (m_pend && vb) begin
      m_front = 1 - m_front;
      m_pend = 0;
      e_sdone = 1;
    end else begin
      if (swap_req) m_pend = 1;
      if (clear_req) begin
        m_clearing = 1;
        m_fill_val = int'(fill_data);
        m_fill_bank = 1 - m_front;
        expect_write(m_fill_bank, 0, m_fill_val);
        m_fill_next = 1;
        m_fill_left = DEPTH - 1;
        e_busy = 1;
      end else begin
        who = -1;
        if (req0_valid && req1_valid) who = m_prefer1 ? 1 : 0;
        else if (req0_valid) who = 0;
        else if (req1_valid) who = 1;
        if (who >= 0) begin
          a = (who == 1) ? int'(req1_addr) : int'(req0_addr);
          d = (who == 1) ? int'(req1_data) : int'(req0_data);
          if (who == 0) e_r0 = 1;
          else e_r1 = 1;
          m_prefer1 = (who == 0);
          if (BOUNDS && a >= DEPTH) m_err = 1;
          else expect_write(1 - m_front, a, d);
        end
      end
    end
  endtask

  task automatic step();
    #1;
    model_step();
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    @(posedge clk);
    #1;
    check("bank0_we", bank0_we, e_we0);
    check("bank1_we", bank1_we, e_we1);
    check("busy", busy, e_busy);
    check("clear_done", clear_done, e_cdone);
    check("swap_done", swap_done, e_sdone);
    check("disp_bank", disp_bank, 32'(m_front));
    check("wr_err", wr_err, m_err);
    if (e_wr) begin
      check("wr_addr", wr_addr, 32'(e_addr));
      check("wr_data", wr_data, 32'(e_data));
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 63) == 0)
      return 16'($urandom_range(DEPTH, 65535));
    return 16'($urandom_range(0, DEPTH - 1));
  endfunction

  // Probabilities are per thousand.
  task automatic rand_in(input int p_vb, input int p_swap,
                         input int p_clr);
    req0_valid = 1'($urandom_range(0, 1));
    req1_valid = 1'($urandom_range(0, 1));
    req0_addr  = rand_addr();
    req1_addr  = rand_addr();
    req0_data  = 8'($urandom);
    req1_data  = 8'($urandom);
    fill_data  = 8'($urandom);
    if (int'($urandom_range(0, 999)) < p_vb) begin
      vc = 10'(VLINES);
      hc = 10'd0;
    end else begin
      vc = 10'($urandom_range(0, 524));
      hc = 10'($urandom_range(1, 799));
    end
    swap_req  = int'($urandom_range(0, 999)) < p_swap;
    clear_req = int'($urandom_range(0, 999)) < p_clr;
  endtask

  task automatic quiet();
    req0_valid = 0; req1_valid = 0;
    swap_req = 0; clear_req = 0;
    vc = 10'd0; hc = 10'd5;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    repeat (3) begin
      rand_in(50, 50, 50);
      step();
    end
    rst = 1'b1;

    quiet();
    req0_valid = 1; req0_addr = 16'd5; req0_data = 8'hE0;
    step();
    check("t1_bank1_we", bank1_we, 1'b1);
    check("t1_wr_addr", wr_addr, 16'd5);

    quiet();
    req0_valid = 1; req1_valid = 1;
    req0_addr = 16'd10; req1_addr = 16'd20;
    repeat (4) step();

    quiet();
    vc = 10'd100;
    swap_req = 1;
    step();
    swap_req = 0;
    repeat (5) step();
    vc = 10'(VLINES); hc = 10'd0;
    req0_valid = 1;
    step();
    quiet();
    req0_valid = 1; req0_addr = 16'd7;
    step();
    check("t3_bank0_we", bank0_we, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rand_in(20, 10, 0);
      step();
    end

    quiet();
    clear_req = 1; fill_data = 8'h03;
    step();
    for (int i = 0; i < DEPTH + 6; i++) begin
      rand_in(0, 0, (i < DEPTH - 5) ? 200 : 0);
      if (i == 10) swap_req = 1;
      if (i == 20000) begin
        vc = 10'(VLINES); hc = 10'd0;
      end
      step();
    end

    for (int i = 0; i < 2000; i++) begin
      rand_in(20, 10, 0);
      step();
    end

    quiet();
    clear_req = 1;
    step();
    for (int i = 0; i < 100; i++) begin
      rand_in(10, 10, 100);
      step();
    end
    rst = 1'b0;
    step();
    check("t5_busy", busy, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rand_in(20, 10, 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
